// File: rtl/romctl.sv
// romctl: NeoGS flash ROM controller with auto-increment address, timed writes and read prefetch.
// Optional write protection below WP_TOP is enabled by defining ROMCTL_WRPROT_EN.
module romctl #(
    parameter int          RD_CYC   = 4,
    parameter int          WE_SETUP = 1,
    parameter int          WE_CYC   = 4,
    parameter int          WE_HOLD  = 1,
    parameter int          INIT_CYC = 16,
    parameter logic [18:0] WP_TOP   = 19'h08000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        wr_addr,
    input  logic        wr_data,
    input  logic        rd_data,
    input  logic [7:0]  wr_buffer,
    output logic [7:0]  rd_buffer,
    output logic        init_in_progress,
    output logic        busy,
    output logic        ovr,
    output logic        wp_hit,
    output logic [18:0] rom_a,
    inout  wire  [7:0]  rom_d,
    output logic        rom_cs_n,
    output logic        rom_oe_n,
    output logic        rom_we_n
);

    localparam logic [7:0] RD_LD   = 8'(RD_CYC - 1);
    localparam logic [7:0] WSU_LD  = 8'(WE_SETUP - 1);
    localparam logic [7:0] WPL_LD  = 8'(WE_CYC - 1);
    localparam logic [7:0] WHD_LD  = 8'(WE_HOLD - 1);
    localparam logic [7:0] INIT_LD = 8'(INIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RD,
        S_WSU,
        S_WPL,
        S_WHD
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADDR,
        OP_WR,
        OP_RD
    } op_t;

    state_t      state;
    state_t      nxt_state;
    logic [7:0]  cnt;
    logic [7:0]  nxt_cnt;
    logic [18:0] address;
    logic [18:0] nxt_addr;
    logic [7:0]  wdata;
    logic [7:0]  nxt_wdata;
    op_t         pend_op;
    op_t         nxt_pend;
    logic [7:0]  pend_data;
    logic [7:0]  nxt_pdata;
    logic        nxt_ovr;
    logic        wp_q;
    logic        nxt_wp;
    logic        init_rd;
    logic        nxt_init_rd;
    logic [7:0]  nxt_rdbuf;
    logic        drive;

    logic        nxt_cs_n;
    logic        nxt_oe_n;
    logic        nxt_we_n;
    logic        nxt_drv;

    op_t         new_op;
    op_t         srv_op;
    logic [7:0]  srv_data;
    logic        multi;
    logic        direct;
    logic        protect;

`ifdef ROMCTL_WRPROT_EN
    assign protect = address < WP_TOP;
`else
    logic unused_wp;
    assign protect   = 1'b0;
    assign unused_wp = ^WP_TOP;
`endif

    assign busy             = state != S_IDLE;
    assign init_in_progress = (state == S_INIT) || init_rd;
    assign wp_hit           = wp_q;
    assign rom_d            = drive ? wdata : 8'hzz;

    assign multi  = (wr_addr & (wr_data | rd_data)) | (wr_data & rd_data);
    assign direct = (state == S_IDLE) && (pend_op == OP_NONE);

    always_comb begin
        new_op = OP_NONE;
        if (wr_addr)
            new_op = OP_ADDR;
        else if (wr_data)
            new_op = OP_WR;
        else if (rd_data)
            new_op = OP_RD;
    end

    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_addr    = address;
        nxt_wdata   = wdata;
        nxt_pend    = pend_op;
        nxt_pdata   = pend_data;
        nxt_ovr     = ovr;
        nxt_wp      = wp_q;
        nxt_init_rd = init_rd;
        nxt_rdbuf   = rd_buffer;
        srv_op      = OP_NONE;
        srv_data    = 8'h00;
        if (init) begin
            nxt_state   = S_INIT;
            nxt_cnt     = INIT_LD;
            nxt_addr    = '0;
            nxt_pend    = OP_NONE;
            nxt_ovr     = 1'b0;
            nxt_wp      = 1'b0;
            nxt_init_rd = 1'b0;
        end else begin
            if (multi)
                nxt_ovr = 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (pend_op != OP_NONE) begin
                        srv_op   = pend_op;
                        srv_data = pend_data;
                        nxt_pend = OP_NONE;
                    end else begin
                        srv_op   = new_op;
                        srv_data = wr_buffer;
                    end
                end
                S_INIT: begin
                    if (cnt == 8'd0) begin
                        nxt_state   = S_RD;
                        nxt_cnt     = RD_LD;
                        nxt_init_rd = 1'b1;
                    end else begin
                        nxt_cnt = cnt - 8'd1;
                    end
                end
                S_RD: begin
                    if (cnt == 8'd0) begin
                        nxt_state   = S_IDLE;
                        nxt_rdbuf   = rom_d;
                        nxt_init_rd = 1'b0;
                    end else begin
                        nxt_cnt = cnt - 8'd1;
                    end
                end
                S_WSU: begin
                    if (cnt == 8'd0) begin
                        nxt_state = S_WPL;
                        nxt_cnt   = WPL_LD;
                    end else begin
                        nxt_cnt = cnt - 8'd1;
                    end
                end
                S_WPL: begin
                    if (cnt == 8'd0) begin
                        nxt_state = S_WHD;
                        nxt_cnt   = WHD_LD;
                    end else begin
                        nxt_cnt = cnt - 8'd1;
                    end
                end
                S_WHD: begin
                    if (cnt == 8'd0) begin
                        nxt_state = S_RD;
                        nxt_cnt   = RD_LD;
                        nxt_addr  = address + 19'd1;
                    end else begin
                        nxt_cnt = cnt - 8'd1;
                    end
                end
                default: begin
                    nxt_state = S_INIT;
                    nxt_cnt   = INIT_LD;
                end
            endcase
            // The slot is freed in the same IDLE cycle that services it.
            if (new_op != OP_NONE && !direct) begin
                if (nxt_pend == OP_NONE) begin
                    nxt_pend  = new_op;
                    nxt_pdata = wr_buffer;
                end else begin
                    nxt_ovr = 1'b1;
                end
            end
            unique case (srv_op)
                OP_ADDR: begin
                    nxt_addr  = {address[10:0], srv_data};
                    nxt_state = S_RD;
                    nxt_cnt   = RD_LD;
                end
                OP_WR: begin
                    if (protect) begin
                        nxt_wp    = 1'b1;
                        nxt_addr  = address + 19'd1;
                        nxt_state = S_RD;
                        nxt_cnt   = RD_LD;
                    end else begin
                        nxt_wdata = srv_data;
                        nxt_state = S_WSU;
                        nxt_cnt   = WSU_LD;
                    end
                end
                OP_RD: begin
                    nxt_addr  = address + 19'd1;
                    nxt_state = S_RD;
                    nxt_cnt   = RD_LD;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt_cs_n = 1'b1;
        nxt_oe_n = 1'b1;
        nxt_we_n = 1'b1;
        nxt_drv  = 1'b0;
        unique case (nxt_state)
            S_RD: begin
                nxt_cs_n = 1'b0;
                nxt_oe_n = 1'b0;
            end
            S_WSU, S_WHD: begin
                nxt_cs_n = 1'b0;
                nxt_drv  = 1'b1;
            end
            S_WPL: begin
                nxt_cs_n = 1'b0;
                nxt_we_n = 1'b0;
                nxt_drv  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            cnt       <= INIT_LD;
            address   <= '0;
            wdata     <= 8'h00;
            pend_op   <= OP_NONE;
            pend_data <= 8'h00;
            ovr       <= 1'b0;
            wp_q      <= 1'b0;
            init_rd   <= 1'b0;
            rd_buffer <= 8'hFF;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            address   <= nxt_addr;
            wdata     <= nxt_wdata;
            pend_op   <= nxt_pend;
            pend_data <= nxt_pdata;
            ovr       <= nxt_ovr;
            wp_q      <= nxt_wp;
            init_rd   <= nxt_init_rd;
            rd_buffer <= nxt_rdbuf;
        end
    end

    // Flash pins come straight from flops so the bus sees no decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_cs_n <= 1'b1;
            rom_oe_n <= 1'b1;
            rom_we_n <= 1'b1;
            drive    <= 1'b0;
            rom_a    <= '0;
        end else begin
            rom_cs_n <= nxt_cs_n;
            rom_oe_n <= nxt_oe_n;
            rom_we_n <= nxt_we_n;
            drive    <= nxt_drv;
            rom_a    <= nxt_addr;
        end
    end

endmodule

// File: tb/tb_romctl.sv
// tb_romctl: scoreboard bench for romctl with a flash device model and a reference address/memory model.
// Build with ROMCTL_WRPROT_EN to also exercise write protection.
module tb_romctl;

    localparam int WE_CYC = 4;

    typedef struct packed {
        logic [18:0] a;
        logic [7:0]  d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        init = 1'b0;
    logic        wr_addr = 1'b0;
    logic        wr_data = 1'b0;
    logic        rd_data = 1'b0;
    logic [7:0]  wr_buffer = 8'h00;
    logic [7:0]  rd_buffer;
    logic        init_in_progress;
    logic        busy;
    logic        ovr;
    logic        wp_hit;
    logic [18:0] rom_a;
    wire  [7:0]  rom_d;
    logic        rom_cs_n;
    logic        rom_oe_n;
    logic        rom_we_n;

    int checks = 0;
    int failures = 0;

    logic [7:0]  dev_mem [0:524287];
    logic [7:0]  ref_mem [logic [18:0]];
    logic [18:0] ref_addr = '0;
    logic        ref_ovr = 1'b0;
    logic        ref_wp = 1'b0;
    ev_t         rd_q[$];
    ev_t         wr_q[$];
    logic        ignore_we = 1'b0;
    logic        prev_busy = 1'b1;
    int          we_len = 0;
    logic [18:0] we_a;
    logic [7:0]  we_d;

    romctl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .init             (init),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .rd_data          (rd_data),
        .wr_buffer        (wr_buffer),
        .rd_buffer        (rd_buffer),
        .init_in_progress (init_in_progress),
        .busy             (busy),
        .ovr              (ovr),
        .wp_hit           (wp_hit),
        .rom_a            (rom_a),
        .rom_d            (rom_d),
        .rom_cs_n         (rom_cs_n),
        .rom_oe_n         (rom_oe_n),
        .rom_we_n         (rom_we_n)
    );

    always #5 clk = ~clk;

    assign rom_d = (!rom_cs_n && !rom_oe_n) ? dev_mem[rom_a] : 8'hzz;

    function automatic logic [7:0] fbyte(input logic [18:0] a);
        return a[7:0] ^ {a[15:13], a[18:16], a[9:8]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [18:0] a);
        if (ref_mem.exists(a))
            return ref_mem[a];
        return fbyte(a);
    endfunction

    function automatic logic ref_protected(input logic [18:0] a);
`ifdef ROMCTL_WRPROT_EN
        return a < 19'h08000;
`else
        return a != a;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_read();
        ev_t e;
        e.a = ref_addr;
        e.d = ref_byte(ref_addr);
        rd_q.push_back(e);
    endtask

    task automatic exp_write(input logic [7:0] d);
        ev_t e;
        if (ref_protected(ref_addr)) begin
            ref_wp = 1'b1;
        end else begin
            e.a = ref_addr;
            e.d = d;
            wr_q.push_back(e);
            ref_mem[ref_addr] = d;
        end
        ref_addr = ref_addr + 19'd1;
    endtask

    task automatic pulse(input logic a, input logic w, input logic r, input logic [7:0] d);
        @(posedge clk);
        #1;
        wr_addr   = a;
        wr_data   = w;
        rd_data   = r;
        wr_buffer = d;
        @(posedge clk);
        #1;
        wr_addr = 1'b0;
        wr_data = 1'b0;
        rd_data = 1'b0;
    endtask

    task automatic wait_quiet();
        int q = 0;
        int n = 0;
        while (q < 2 && n < 400) begin
            @(negedge clk);
            n++;
            if (!busy)
                q++;
            else
                q = 0;
        end
        check("idle_reached", 32'(q >= 2), 32'd1);
    endtask

    task automatic do_op(input int op, input logic [7:0] d);
        case (op)
            0: begin
                pulse(1'b1, 1'b0, 1'b0, d);
                ref_addr = {ref_addr[10:0], d};
            end
            1: begin
                pulse(1'b0, 1'b1, 1'b0, d);
                exp_write(d);
            end
            default: begin
                pulse(1'b0, 1'b0, 1'b1, d);
                ref_addr = ref_addr + 19'd1;
            end
        endcase
        exp_read();
        wait_quiet();
    endtask

    // Read scoreboard: every return to IDLE presents a freshly prefetched byte.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            prev_busy = 1'b1;
        end else begin
            if (prev_busy && !busy) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 32'(rom_a), 32'h7FFFFFFF);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_addr", 32'(rom_a), 32'(e.a));
                    check("rd_byte", 32'(rd_buffer), 32'(e.d));
                end
            end
            prev_busy = busy;
        end
    end

    // Flash device write capture plus write scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            we_len = 0;
        end else if (!rom_we_n) begin
            we_len++;
            we_a = rom_a;
            we_d = rom_d;
            check("we_cs_low", 32'(rom_cs_n), 32'd0);
        end else if (we_len > 0) begin
            if (we_len == WE_CYC)
                dev_mem[we_a] = we_d;
            if (ignore_we) begin
                ignore_we = 1'b0;
            end else if (wr_q.size() == 0) begin
                check("we_unexpected", 32'(we_a), 32'h7FFFFFFF);
            end else begin
                e = wr_q.pop_front();
                check("we_len", 32'(we_len), 32'(WE_CYC));
                check("we_addr", 32'(we_a), 32'(e.a));
                check("we_data", 32'(we_d), 32'(e.d));
            end
            we_len = 0;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 524288; i++)
            dev_mem[i] = fbyte(19'(i));
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_iip", 32'(init_in_progress), 32'd1);
        check("rst_rdbuf", 32'(rd_buffer), 32'hFF);
        check("rst_ctl", 32'({rom_cs_n, rom_oe_n, rom_we_n}), 32'h7);
        check("rst_rom_a", 32'(rom_a), 32'd0);
        check("rst_flags", 32'({ovr, wp_hit}), 32'd0);

        ref_addr = '0;
        exp_read();
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!rom_cs_n)
                break;
            n++;
        end
        check("init_idle_clks", 32'(n), 32'd16);
        check("init_first_rd_iip", 32'(init_in_progress), 32'd1);
        check("init_first_rd_oe", 32'(rom_oe_n), 32'd0);
        wait_quiet();
        check("iip_dropped", 32'(init_in_progress), 32'd0);

        do_op(0, 8'h01);
        do_op(0, 8'h23);
        do_op(0, 8'h45);
        check("addr_12345", 32'(rom_a), 32'h12345);

        do_op(0, 8'h07);
        do_op(0, 8'hFF);
        do_op(0, 8'hFF);
        check("addr_7ffff", 32'(rom_a), 32'h7FFFF);
        do_op(1, 8'hA5);
        check("addr_wrapped", 32'(rom_a), 32'd0);

        for (int i = 0; i < 40; i++)
            do_op(int'($urandom_range(0, 2)), 8'($urandom));
        check("ovr_clean", 32'(ovr), 32'(ref_ovr));
        check("wp_model", 32'(wp_hit), 32'(ref_wp));

        // Three back-to-back rd_data: one served, one pending, one dropped.
        @(posedge clk);
        #1 rd_data = 1'b1;
        repeat (3) @(posedge clk);
        #1 rd_data = 1'b0;
        ref_addr = ref_addr + 19'd1;
        exp_read();
        ref_addr = ref_addr + 19'd1;
        exp_read();
        ref_ovr = 1'b1;
        wait_quiet();
        check("ovr_dropped", 32'(ovr), 32'(ref_ovr));

        // init during the WE_n low phase of a write.
        ignore_we = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, 8'h77);
        n = 0;
        while (rom_we_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wpl_reached", 32'(rom_we_n), 32'd0);
        init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        check("abort_we_high", 32'(rom_we_n), 32'd1);
        check("abort_cs_high", 32'(rom_cs_n), 32'd1);
        check("abort_addr", 32'(rom_a), 32'd0);
        check("abort_ovr", 32'(ovr), 32'd0);
        check("abort_iip", 32'(init_in_progress), 32'd1);
        ref_addr = '0;
        ref_ovr = 1'b0;
        ref_wp = 1'b0;
        exp_read();
        wait_quiet();
        check("abort_iip_done", 32'(init_in_progress), 32'd0);

        // Simultaneous wr_data and rd_data: the write wins, rd_data is lost.
        pulse(1'b0, 1'b1, 1'b1, 8'h3C);
        exp_write(8'h3C);
        exp_read();
        ref_ovr = 1'b1;
        wait_quiet();
        check("ovr_simul", 32'(ovr), 32'(ref_ovr));

`ifdef ROMCTL_WRPROT_EN
        do_op(0, 8'h00);
        do_op(0, 8'h01);
        do_op(0, 8'h00);
        do_op(1, 8'hC3);
        check("wp_hit_set", 32'(wp_hit), 32'd1);
        check("wp_addr", 32'(rom_a), 32'h00101);
`endif

        repeat (4) @(negedge clk);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
